// File: rtl/report_out_arbiter.sv
// Round-robin packet arbiter merging ARM report and SSM sample streams onto one
// 134-bit path, with per-source data/valid FIFOs, invalid-packet discard and counters.
module report_out_arbiter #(
  parameter int unsigned DATA_AW    = 8,
  parameter int unsigned VLD_AW     = 6,
  parameter int unsigned ALF_MARGIN = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cnt_rst,
  input  logic [133:0] in_arm_data,
  input  logic         in_arm_data_wr,
  input  logic         in_arm_data_valid,
  input  logic         in_arm_data_valid_wr,
  input  logic [133:0] in_ssm_data,
  input  logic         in_ssm_data_wr,
  input  logic         in_ssm_data_valid,
  input  logic         in_ssm_data_valid_wr,
  output logic         out_arm_alf,
  output logic         out_ssm_alf,
  input  logic         in_os_alf,
  output logic [133:0] out_data,
  output logic         out_data_wr,
  output logic         out_data_valid,
  output logic         out_data_valid_wr,
  output logic [31:0]  out_arm_pkt_cnt,
  output logic [31:0]  out_ssm_pkt_cnt,
  output logic [31:0]  out_drop_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, DISCARD} state_t;

  localparam logic [DATA_AW:0] DATA_ALF_TH = (DATA_AW+1)'((1 << DATA_AW) - ALF_MARGIN);
  localparam logic [VLD_AW:0]  VLD_ALF_TH  = (VLD_AW+1)'((1 << VLD_AW) - 2);

  // Source index 0 is ARM, 1 is SSM throughout.
  logic [1:0][133:0] d_din, d_dout;
  logic [1:0] d_wr, d_rd, d_drop, d_empty;
  logic [1:0] v_wr, v_din, v_rd, v_dout, v_drop, v_empty;
  logic [1:0] alf, cand, grant;

  assign d_din = {in_ssm_data, in_arm_data};
  assign d_wr  = {in_ssm_data_wr, in_arm_data_wr};
  assign v_din = {in_ssm_data_valid, in_arm_data_valid};
  assign v_wr  = {in_ssm_data_valid_wr, in_arm_data_valid_wr};

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [133:0]       mem  [1 << DATA_AW];
    logic               vmem [1 << VLD_AW];
    logic [DATA_AW-1:0] wp, rp;
    logic [DATA_AW:0]   used;
    logic [VLD_AW-1:0]  vwp, vrp;
    logic [VLD_AW:0]    vused;
    logic               dw, dr, vw, vr;

    // A write into a full FIFO is still accepted when a pop frees a slot that cycle.
    assign dr = d_rd[s] && (used != '0);
    assign dw = d_wr[s] && (!used[DATA_AW] || dr);
    assign vr = v_rd[s] && (vused != '0);
    assign vw = v_wr[s] && (!vused[VLD_AW] || vr);

    assign d_drop[s]  = d_wr[s] && !dw;
    assign v_drop[s]  = v_wr[s] && !vw;
    assign d_empty[s] = (used == '0);
    assign v_empty[s] = (vused == '0);
    assign d_dout[s]  = mem[rp];
    assign v_dout[s]  = vmem[vrp];
    assign alf[s]     = (used >= DATA_ALF_TH) || (vused >= VLD_ALF_TH);

    always_ff @(posedge clk) begin
      if (dw) mem[wp] <= d_din[s];
      if (vw) vmem[vwp] <= v_din[s];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp    <= '0;
        rp    <= '0;
        used  <= '0;
        vwp   <= '0;
        vrp   <= '0;
        vused <= '0;
      end else begin
        if (dw) wp <= wp + 1'b1;
        if (dr) rp <= rp + 1'b1;
        if (vw) vwp <= vwp + 1'b1;
        if (vr) vrp <= vrp + 1'b1;
        used  <= used + (DATA_AW+1)'(dw) - (DATA_AW+1)'(dr);
        vused <= vused + (VLD_AW+1)'(vw) - (VLD_AW+1)'(vr);
      end
    end
  end

  assign out_arm_alf = alf[0];
  assign out_ssm_alf = alf[1];

  state_t       state;
  logic         sel, prio, os_alf_q;
  logic         data_pop, is_tail, send_tail, disc_tail;
  logic [133:0] cur_word;
  logic [2:0]   drop_add;

  assign cand      = ~v_empty;
  assign cur_word  = d_dout[sel];
  assign is_tail   = (cur_word[133:132] == 2'b10);
  assign data_pop  = (state != IDLE) && !d_empty[sel];
  assign d_rd      = data_pop ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign v_rd      = grant;
  assign send_tail = (state == SEND) && data_pop && is_tail;
  assign disc_tail = (state == DISCARD) && data_pop && is_tail;

  // Downstream almost-full is registered, so a deassertion is seen by the grant a cycle later.
  always_comb begin
    grant = '0;
    if (state == IDLE && !os_alf_q) begin
      if (cand[prio])       grant[prio]  = 1'b1;
      else if (cand[~prio]) grant[~prio] = 1'b1;
    end
  end

  always_comb begin
    drop_add = 3'(d_drop[0]) + 3'(d_drop[1]) + 3'(v_drop[0]) + 3'(v_drop[1]) + 3'(disc_tail);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      sel               <= 1'b0;
      prio              <= 1'b0;
      os_alf_q          <= 1'b0;
      out_data          <= '0;
      out_data_wr       <= 1'b0;
      out_data_valid    <= 1'b0;
      out_data_valid_wr <= 1'b0;
    end else begin
      os_alf_q          <= in_os_alf;
      out_data_wr       <= 1'b0;
      out_data_valid    <= 1'b0;
      out_data_valid_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            sel   <= grant[1];
            state <= v_dout[grant[1]] ? SEND : DISCARD;
          end
        end
        SEND: begin
          if (data_pop) begin
            out_data    <= cur_word;
            out_data_wr <= 1'b1;
            if (is_tail) begin
              out_data_valid    <= 1'b1;
              out_data_valid_wr <= 1'b1;
              prio              <= ~sel;
              state             <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (data_pop && is_tail) begin
            prio  <= ~sel;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_arm_pkt_cnt <= '0;
      out_ssm_pkt_cnt <= '0;
      out_drop_cnt    <= '0;
    end else if (cnt_rst) begin
      out_arm_pkt_cnt <= '0;
      out_ssm_pkt_cnt <= '0;
      out_drop_cnt    <= '0;
    end else begin
      if (send_tail && !sel) out_arm_pkt_cnt <= out_arm_pkt_cnt + 1'b1;
      if (send_tail && sel)  out_ssm_pkt_cnt <= out_ssm_pkt_cnt + 1'b1;
      out_drop_cnt <= out_drop_cnt + 32'(drop_add);
    end
  end

endmodule

// File: tb/tb_report_out_arbiter.sv
// Directed self-checking bench for report_out_arbiter: framing, round-robin,
// downstream back-pressure, discard, FIFO fill/drop, counter clear and reset.
module tb_report_out_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cnt_rst = 1'b0;
  logic [133:0] in_arm_data = '0;
  logic         in_arm_data_wr = 1'b0;
  logic         in_arm_data_valid = 1'b0;
  logic         in_arm_data_valid_wr = 1'b0;
  logic [133:0] in_ssm_data = '0;
  logic         in_ssm_data_wr = 1'b0;
  logic         in_ssm_data_valid = 1'b0;
  logic         in_ssm_data_valid_wr = 1'b0;
  logic         out_arm_alf, out_ssm_alf;
  logic         in_os_alf = 1'b0;
  logic [133:0] out_data;
  logic         out_data_wr, out_data_valid, out_data_valid_wr;
  logic [31:0]  out_arm_pkt_cnt, out_ssm_pkt_cnt, out_drop_cnt;

  report_out_arbiter #(.DATA_AW(8), .VLD_AW(6), .ALF_MARGIN(40)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_rst(cnt_rst),
    .in_arm_data(in_arm_data), .in_arm_data_wr(in_arm_data_wr),
    .in_arm_data_valid(in_arm_data_valid), .in_arm_data_valid_wr(in_arm_data_valid_wr),
    .in_ssm_data(in_ssm_data), .in_ssm_data_wr(in_ssm_data_wr),
    .in_ssm_data_valid(in_ssm_data_valid), .in_ssm_data_valid_wr(in_ssm_data_valid_wr),
    .out_arm_alf(out_arm_alf), .out_ssm_alf(out_ssm_alf), .in_os_alf(in_os_alf),
    .out_data(out_data), .out_data_wr(out_data_wr), .out_data_valid(out_data_valid),
    .out_data_valid_wr(out_data_valid_wr), .out_arm_pkt_cnt(out_arm_pkt_cnt),
    .out_ssm_pkt_cnt(out_ssm_pkt_cnt), .out_drop_cnt(out_drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tail_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output words captured on the falling edge, stamped with the rising-edge count.
  logic [133:0] qd[$];
  int           qc[$];
  bit           qt[$];

  always @(negedge clk) begin
    if (out_data_wr === 1'b1) begin
      qd.push_back(out_data);
      qc.push_back(cyc);
      qt.push_back(out_data_valid_wr === 1'b1 && out_data_valid === 1'b1);
    end
  end

  function automatic logic [133:0] mk(input int src, input int tag, input int idx, input int n);
    logic [133:0] w;
    w = '0;
    w[133:132] = (idx == 0) ? 2'b01 : (idx == n - 1) ? 2'b10 : 2'b11;
    w[31:24] = 8'(src);
    w[23:16] = 8'(tag);
    w[15:0]  = 16'(idx);
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    qd.delete();
    qc.delete();
    qt.delete();
  endtask

  task automatic clear_wr;
    in_arm_data_wr = 1'b0; in_arm_data_valid_wr = 1'b0; in_arm_data_valid = 1'b0;
    in_ssm_data_wr = 1'b0; in_ssm_data_valid_wr = 1'b0; in_ssm_data_valid = 1'b0;
  endtask

  task automatic write_pkt(input int src, input int tag, input int n, input bit vld);
    for (int i = 0; i < n; i++) begin
      if (src == 0) begin
        in_arm_data = mk(0, tag, i, n); in_arm_data_wr = 1'b1;
        in_arm_data_valid_wr = (i == n - 1); in_arm_data_valid = vld;
      end else begin
        in_ssm_data = mk(1, tag, i, n); in_ssm_data_wr = 1'b1;
        in_ssm_data_valid_wr = (i == n - 1); in_ssm_data_valid = vld;
      end
      tick;
    end
    tail_cyc = cyc;
    clear_wr;
  endtask

  task automatic write_pair(input int tag_a, input int tag_s, input int n);
    for (int i = 0; i < n; i++) begin
      in_arm_data = mk(0, tag_a, i, n); in_arm_data_wr = 1'b1;
      in_arm_data_valid_wr = (i == n - 1); in_arm_data_valid = 1'b1;
      in_ssm_data = mk(1, tag_s, i, n); in_ssm_data_wr = 1'b1;
      in_ssm_data_valid_wr = (i == n - 1); in_ssm_data_valid = 1'b1;
      tick;
    end
    clear_wr;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (qd.size() < n && k < budget) begin
      tick;
      k++;
    end
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    checks++;
    if ({out_data, out_data_wr, out_data_valid, out_data_valid_wr} !== '0) begin
      errors++;
      $display("FAIL reset_out: got %0h wr=%b v=%b vwr=%b required all 0", out_data, out_data_wr, out_data_valid, out_data_valid_wr);
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if ({out_arm_pkt_cnt, out_ssm_pkt_cnt, out_drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got arm=%0d ssm=%0d drop=%0d required 0", out_arm_pkt_cnt, out_ssm_pkt_cnt, out_drop_cnt);
    end
    checks++;
    if ({out_arm_alf, out_ssm_alf, out_data_wr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_alf: got arm_alf=%b ssm_alf=%b wr=%b required 0", out_arm_alf, out_ssm_alf, out_data_wr);
    end
  endtask

  task automatic test_round_robin;
    int bad;
    for (int pass = 0; pass < 2; pass++) begin
      clear_q;
      write_pair(1 + 2 * pass, 2 + 2 * pass, 4);
      wait_words(8, 40);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        if (i >= qd.size()) bad++;
        else if (qd[i] !== ((i < 4) ? mk(0, 1 + 2 * pass, i, 4) : mk(1, 2 + 2 * pass, i - 4, 4))) bad++;
        else if (qt[i] !== (i == 3 || i == 7)) bad++;
      end
      checks++;
      if (bad !== 0 || qd.size() !== 8) begin
        errors++;
        $display("FAIL rr_order pass %0d: got %0d words %0d bad required 8 words ARM then SSM", pass, qd.size(), bad);
      end
      if (qd.size() == 8) begin
        checks++;
        if (qc[4] < qc[3] + 2 || qc[3] !== qc[0] + 3 || qc[7] !== qc[4] + 3) begin
          errors++;
          $display("FAIL rr_spacing pass %0d: got cycles %0d..%0d then %0d..%0d required contiguous with idle gap", pass, qc[0], qc[3], qc[4], qc[7]);
        end
      end
    end
    checks++;
    if (out_arm_pkt_cnt !== 32'd2 || out_ssm_pkt_cnt !== 32'd2) begin
      errors++;
      $display("FAIL rr_cnt: got arm=%0d ssm=%0d required 2 and 2", out_arm_pkt_cnt, out_ssm_pkt_cnt);
    end
  endtask

  task automatic test_single_arm;
    int bad, t;
    clear_q;
    write_pkt(0, 5, 37, 1'b1);
    t = tail_cyc;
    wait_words(37, 80);
    bad = 0;
    for (int i = 0; i < 37; i++) begin
      if (i >= qd.size()) bad++;
      else if (qd[i] !== mk(0, 5, i, 37) || qt[i] !== (i == 36) || qc[i] !== t + 2 + i) bad++;
    end
    checks++;
    if (qd.size() !== 37) begin
      errors++;
      $display("FAIL single_len: got %0d words required 37", qd.size());
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL single_words: got %0d bad words (first at cycle %0d) required 0, first at %0d", bad, (qc.size() > 0) ? qc[0] : -1, t + 2);
    end
    checks++;
    if (out_arm_pkt_cnt !== 32'd3 || out_data_wr !== 1'b0) begin
      errors++;
      $display("FAIL single_cnt: got arm=%0d wr=%b required 3 and 0", out_arm_pkt_cnt, out_data_wr);
    end
  endtask

  task automatic test_os_alf;
    int bad, p, k;
    clear_q;
    in_os_alf = 1'b1;
    write_pkt(0, 6, 6, 1'b1);
    repeat (10) tick;
    checks++;
    if (qd.size() !== 0) begin
      errors++;
      $display("FAIL alf_hold: got %0d words while downstream full required 0", qd.size());
    end
    in_os_alf = 1'b0;
    p = cyc;
    k = 0;
    while (qd.size() < 2 && k < 20) begin
      tick;
      k++;
    end
    in_os_alf = 1'b1;
    wait_words(6, 40);
    in_os_alf = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (i >= qd.size()) bad++;
      else if (qd[i] !== mk(0, 6, i, 6) || qc[i] !== p + 3 + i) bad++;
    end
    checks++;
    if (bad !== 0 || qd.size() !== 6) begin
      errors++;
      $display("FAIL alf_release: got %0d words %0d bad (first at %0d) required 6 contiguous from %0d", qd.size(), bad, (qc.size() > 0) ? qc[0] : -1, p + 3);
    end
    checks++;
    if (out_arm_pkt_cnt !== 32'd4) begin
      errors++;
      $display("FAIL alf_cnt: got arm=%0d required 4", out_arm_pkt_cnt);
    end
  endtask

  task automatic test_discard;
    int bad;
    clear_q;
    write_pkt(1, 7, 5, 1'b0);
    write_pkt(1, 8, 4, 1'b1);
    wait_words(4, 60);
    repeat (5) tick;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (i >= qd.size()) bad++;
      else if (qd[i] !== mk(1, 8, i, 4) || qt[i] !== (i == 3)) bad++;
    end
    checks++;
    if (bad !== 0 || qd.size() !== 4) begin
      errors++;
      $display("FAIL discard_words: got %0d words %0d bad required only the 4-word valid packet", qd.size(), bad);
    end
    checks++;
    if (out_drop_cnt !== 32'd1 || out_ssm_pkt_cnt !== 32'd3) begin
      errors++;
      $display("FAIL discard_cnt: got drop=%0d ssm=%0d required 1 and 3", out_drop_cnt, out_ssm_pkt_cnt);
    end
  endtask

  task automatic test_cnt_rst;
    clear_q;
    write_pkt(1, 9, 4, 1'b1);
    repeat (4) tick;
    cnt_rst = 1'b1;
    tick;
    cnt_rst = 1'b0;
    checks++;
    if (out_data_valid_wr !== 1'b1) begin
      errors++;
      $display("FAIL cnt_rst_align: got valid_wr=%b required 1 on tail cycle", out_data_valid_wr);
    end
    tick;
    checks++;
    if ({out_arm_pkt_cnt, out_ssm_pkt_cnt, out_drop_cnt} !== '0) begin
      errors++;
      $display("FAIL cnt_rst: got arm=%0d ssm=%0d drop=%0d required 0", out_arm_pkt_cnt, out_ssm_pkt_cnt, out_drop_cnt);
    end
  endtask

  task automatic test_alf_fill;
    in_arm_data = '0;
    in_arm_data[133:132] = 2'b11;
    in_arm_data_wr = 1'b1;
    repeat (215) tick;
    checks++;
    if (out_arm_alf !== 1'b0) begin
      errors++;
      $display("FAIL alf_215: got %b required 0", out_arm_alf);
    end
    tick;
    checks++;
    if (out_arm_alf !== 1'b1 || out_ssm_alf !== 1'b0) begin
      errors++;
      $display("FAIL alf_216: got arm=%b ssm=%b required 1 and 0", out_arm_alf, out_ssm_alf);
    end
    repeat (40) tick;
    checks++;
    if (out_drop_cnt !== 32'd0) begin
      errors++;
      $display("FAIL fill_256: got drop=%0d required 0", out_drop_cnt);
    end
    repeat (3) tick;
    in_arm_data_wr = 1'b0;
    tick;
    checks++;
    if (out_drop_cnt !== 32'd3 || out_arm_alf !== 1'b1) begin
      errors++;
      $display("FAIL fill_drop: got drop=%0d alf=%b required 3 and 1", out_drop_cnt, out_arm_alf);
    end
  endtask

  task automatic test_reset_mid;
    int bad, k;
    clear_q;
    write_pkt(1, 11, 37, 1'b1);
    k = 0;
    while (qd.size() < 5 && k < 20) begin
      tick;
      k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_data, out_data_wr, out_data_valid_wr, out_arm_alf, out_drop_cnt} !== '0 || qd.size() < 5) begin
      errors++;
      $display("FAIL reset_mid: got wr=%b data=%0h alf=%b drop=%0d seen=%0d required all 0 after 5 words", out_data_wr, out_data, out_arm_alf, out_drop_cnt, qd.size());
    end
    repeat (2) tick;
    rst_n = 1'b1;
    clear_q;
    repeat (10) tick;
    checks++;
    if (qd.size() !== 0 || out_ssm_alf !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: got %0d leftover words ssm_alf=%b required 0", qd.size(), out_ssm_alf);
    end
    write_pkt(0, 12, 4, 1'b1);
    wait_words(4, 30);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (i >= qd.size()) bad++;
      else if (qd[i] !== mk(0, 12, i, 4)) bad++;
    end
    checks++;
    if (bad !== 0 || qd.size() !== 4 || out_arm_pkt_cnt !== 32'd1) begin
      errors++;
      $display("FAIL reset_recover: got %0d words %0d bad arm=%0d required 4 words and arm=1", qd.size(), bad, out_arm_pkt_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single_arm;
    test_os_alf;
    test_discard;
    test_cnt_rst;
    test_alf_fill;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/report_out_arbiter.md
Name: report_out_arbiter

Overview:
Shares the single 134-bit packet path toward FPGA OS between two packet sources: the ARM report generator (37-word report packets) and the SSM sampled-packet stream.
Each source writes into its own internal data FIFO and packet-valid FIFO.
The arbiter forwards whole packets without interleaving, using round-robin between sources.
It honours downstream almost-full, drops packets flagged invalid, and keeps per-source forwarded-packet counters.

Parameters:
DATA_AW, 8, data FIFO address width per source (256 words of 134 bits)
VLD_AW, 6, valid FIFO address width per source (64 packets)
ALF_MARGIN, 40, out_*_alf asserts when data FIFO used words >= 2^DATA_AW - ALF_MARGIN, or valid FIFO used >= 2^VLD_AW - 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cnt_rst  in  1  synchronous clear of packet counters
in_arm_data  in  134  [133:132]=01 head, 11 middle, 10 tail; [127:0] payload
in_arm_data_wr  in  1  write strobe for in_arm_data
in_arm_data_valid  in  1  1 = packet good, 0 = discard
in_arm_data_valid_wr  in  1  strobe, coincident with tail word write
in_ssm_data, in_ssm_data_wr, in_ssm_data_valid, in_ssm_data_valid_wr  in  134/1/1/1  same as ARM set
out_arm_alf  out  1  ARM FIFO almost full
out_ssm_alf  out  1  SSM FIFO almost full
in_os_alf  in  1  downstream almost full
out_data  out  134  forwarded word
out_data_wr  out  1  word strobe
out_data_valid  out  1  always 1 when strobed (invalid packets never forwarded)
out_data_valid_wr  out  1  strobe, coincident with tail word
out_arm_pkt_cnt  out  32  ARM packets forwarded
out_ssm_pkt_cnt  out  32  SSM packets forwarded
out_drop_cnt  out  32  words lost on full FIFO plus packets discarded as invalid

Behaviour:
- Reset values: all outputs 0. FIFOs are emptied. State is IDLE. Round-robin priority points to ARM.
- Writes:
  - data_wr pushes one word. valid_wr pushes one valid bit.
  - A write to a full FIFO is ignored and out_drop_cnt increments by 1.
  - Because valid_wr accompanies the tail, a non-empty valid FIFO means a complete packet is held in the data FIFO.
- States: IDLE, SEND, DISCARD.
- IDLE, at cycle T:
  - Candidates are sources with a non-empty valid FIFO.
  - If in_os_alf=1, nothing is granted.
  - Otherwise the priority source is granted if it is a candidate, else the other source.
  - On grant: pop the valid FIFO. If the valid bit is 1, go to SEND; if 0, go to DISCARD.
  - Write-to-grant: a valid_wr at cycle W is visible to the grant at W+1 at earliest.
- SEND:
  - Pop one data word per cycle, starting at T+1.
  - Each word appears registered on out_data with out_data_wr=1, starting at T+2.
  - The words of an N-word packet are contiguous on T+2..T+N+1.
  - On the tail word (bits 133:132=10): out_data_valid=1 and out_data_valid_wr=1 in the same cycle. The granted source's counter increments. Priority moves to the other source. Return to IDLE.
  - in_os_alf is sampled only at grant; a packet is never interrupted once started.
- DISCARD:
  - Pop words one per cycle until the tail is popped. No out_data_wr.
  - out_drop_cnt increments by 1 at the tail. Priority toggles. Return to IDLE.
- Packet spacing: the next grant is evaluated no earlier than the cycle after the tail leaves, giving at least one idle cycle between packets.
- Counters: 32-bit and wrap to 0 after 0xFFFFFFFF. cnt_rst=1 clears all three, and takes precedence over a simultaneous increment.
- out_*_alf: combinational from the FIFO fill levels, updated the cycle after the write or pop.
- Simultaneous events:
  - A source may write its FIFOs in the same cycle the arbiter pops them; the FIFO used count stays correct.
  - A read and a write on a full FIFO in the same cycle: the write is accepted.
- Reset mid-packet: output stops immediately, all held packets are lost, and counters return to 0.
- Error case: a head word arriving mid-packet is forwarded as-is; no framing repair is done.

Test Plan:
- One 37-word ARM packet with valid=1, in_os_alf=0 → out_data_wr high for 37 consecutive cycles starting 2 cycles after the grant; valid_wr on word 37; out_arm_pkt_cnt=1.
- ARM and SSM 4-word packets completing in the same cycle → ARM forwarded first, SSM next after ≥1 idle cycle. A second simultaneous pair → ARM first again, because priority alternates per packet.
- in_os_alf=1 while a packet is pending → no output. Deassert → grant the next cycle, first word 2 cycles later. Assert alf mid-packet → packet still completes uninterrupted.
- SSM 5-word packet with valid=0 → no output words; out_drop_cnt=1; a following valid SSM packet is forwarded correctly.
- Fill the ARM data FIFO to 216 words → out_arm_alf=1. Write to 256 words, then 3 more → out_drop_cnt=3.
- cnt_rst pulsed on the same cycle as a tail → counter reads 0. rst_n pulled low mid-packet → all outputs 0 and FIFOs empty; after release, a new packet forwards normally.
